// File: rtl/delayed_io_pkg.sv
// Shared types and defaults for the delayed_io_seq pulse sequencer.
// Optional repeat support is enabled with the DELAYED_IO_REPEAT_EN macro.
package delayed_io_pkg;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_CNT_W  = 32;
  localparam int REPEAT_W       = 16;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_DELAY,
    CH_ACTIVE,
    CH_DONE
  } ch_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/delayed_io_seq_ch.sv
// One delayed-pulse channel: FSM, down-counter and registered pin.
// With DELAYED_IO_REPEAT_EN a finished channel can be relaunched from its latched settings.
module delayed_io_seq_ch
  import delayed_io_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             clear,
`ifdef DELAYED_IO_REPEAT_EN
  input  logic             restart,
  output logic             skip,
`endif
  input  logic             en,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic             polarity,
  output logic             pin,
  output logic             busy,
  output logic             fin
);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] width_q;
  logic             en_q;
  logic             pol_q;
  logic             launch;
  logic [CNT_W-1:0] l_delay;
  logic [CNT_W-1:0] l_width;
  logic             l_pol;

  // The counter holds "cycles remaining minus one", so W=0 collapses onto W=1.
  function automatic logic [CNT_W-1:0] width_load(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  // A launch from IDLE uses the live inputs; a relaunch from DONE uses the latched copy.
  assign l_delay = (state == CH_IDLE) ? delay    : delay_q;
  assign l_width = (state == CH_IDLE) ? width    : width_q;
  assign l_pol   = (state == CH_IDLE) ? polarity : pol_q;

`ifdef DELAYED_IO_REPEAT_EN
  assign launch = (state == CH_IDLE && start && en) ||
                  (state == CH_DONE && restart && en_q);
  assign skip   = restart && en_q && (state != CH_DONE);
`else
  assign launch = state == CH_IDLE && start && en;
`endif

  assign busy = (state == CH_DELAY) || (state == CH_ACTIVE);
  assign fin  = !en_q || (state == CH_DONE) || (state == CH_ACTIVE && cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every channel and the
  // top-level FSM all update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the latched configuration is reset as well, so fin is defined
      // before the first start edge ever arrives.
      state   <= CH_IDLE;
      cnt     <= '0;
      delay_q <= '0;
      width_q <= '0;
      en_q    <= 1'b0;
      pol_q   <= 1'b0;
      pin     <= ~polarity;
    end else if (abort) begin
      state <= CH_IDLE;
      cnt   <= '0;
      pin   <= ~polarity;
    end else begin
      if (start) begin
        en_q    <= en;
        delay_q <= delay;
        width_q <= width;
        pol_q   <= polarity;
      end
      if (launch) begin
        if (l_delay == '0) begin
          state <= CH_ACTIVE;
          cnt   <= width_load(l_width);
          pin   <= l_pol;
        end else begin
          state <= CH_DELAY;
          cnt   <= l_delay - CNT_W'(1);
          pin   <= ~l_pol;
        end
      end else begin
        case (state)
          CH_IDLE: pin <= ~polarity;
          CH_DELAY: begin
            if (cnt == '0) begin
              state <= CH_ACTIVE;
              cnt   <= width_load(width_q);
              pin   <= pol_q;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          CH_ACTIVE: begin
            if (cnt == '0) begin
              state <= CH_DONE;
              pin   <= ~pol_q;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          CH_DONE: begin
            if (clear) begin
              state <= CH_IDLE;
              pin   <= ~polarity;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/delayed_io_seq.sv
// Multi-channel delayed pulse sequencer: one start edge launches per-channel delay/width pulses.
// Define DELAYED_IO_REPEAT_EN to add periodic repetition (i_period, i_repeat, o_overrun).
module delayed_io_seq
  import delayed_io_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [NUM_CH-1:0]            i_ch_en,
  input  logic [NUM_CH-1:0][CNT_W-1:0] i_delay,
  input  logic [NUM_CH-1:0][CNT_W-1:0] i_width,
  input  logic [NUM_CH-1:0]            i_polarity,
`ifdef DELAYED_IO_REPEAT_EN
  input  logic [CNT_W-1:0]             i_period,
  input  logic [REPEAT_W-1:0]          i_repeat,
  output logic                         o_overrun,
`endif
  output logic [NUM_CH-1:0]            o_io_pins,
  output logic [NUM_CH-1:0]            o_ch_busy,
  output logic                         o_busy,
  output logic                         o_done
);

  seq_state_t        seq_state;
  logic              start_q;
  logic              start_edge;
  logic              clear;
  logic              seq_finish;
  logic [NUM_CH-1:0] ch_fin;

  assign start_edge = i_start && !start_q && (seq_state == SEQ_IDLE) && !i_abort;
  assign clear      = (seq_state == SEQ_DONE) && !i_start;
  assign o_busy     = |o_ch_busy;

`ifdef DELAYED_IO_REPEAT_EN
  logic [CNT_W-1:0]    per_q;
  logic [CNT_W-1:0]    per_cnt;
  logic [REPEAT_W-1:0] rep_left;
  logic                overrun_q;
  logic                boundary;
  logic [NUM_CH-1:0]   ch_skip;

  // per_cnt reaches zero in the cycle whose closing edge is the period boundary.
  assign boundary   = (seq_state == SEQ_RUN) && (rep_left != '0) && (per_cnt == '0) && !i_abort;
  assign seq_finish = (&ch_fin) && (rep_left == '0);
  assign o_overrun  = overrun_q | (|ch_skip);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_q     <= '0;
      per_cnt   <= '0;
      rep_left  <= '0;
      overrun_q <= 1'b0;
    end else if (start_edge) begin
      per_q     <= i_period;
      per_cnt   <= i_period - CNT_W'(1);
      rep_left  <= (i_period == '0) ? '0 : i_repeat;
      overrun_q <= 1'b0;
    end else begin
      if (boundary) begin
        per_cnt  <= per_q - CNT_W'(1);
        rep_left <= rep_left - REPEAT_W'(1);
      end else if (seq_state == SEQ_RUN && per_cnt != '0) begin
        per_cnt <= per_cnt - CNT_W'(1);
      end
      overrun_q <= overrun_q | (|ch_skip);
    end
  end
`else
  assign seq_finish = &ch_fin;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_state <= SEQ_IDLE;
      start_q   <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      start_q <= i_start;
      if (i_abort) begin
        seq_state <= SEQ_IDLE;
        o_done    <= 1'b0;
      end else begin
        case (seq_state)
          SEQ_IDLE: begin
            if (start_edge) begin
              if (i_ch_en == '0) begin
                seq_state <= SEQ_DONE;
                o_done    <= 1'b1;
              end else begin
                seq_state <= SEQ_RUN;
              end
            end
          end
          // Channels finishing on this edge count, so o_done lines up with their DONE entry.
          SEQ_RUN: begin
            if (seq_finish) begin
              seq_state <= SEQ_DONE;
              o_done    <= 1'b1;
            end
          end
          SEQ_DONE: begin
            if (!i_start) begin
              seq_state <= SEQ_IDLE;
              o_done    <= 1'b0;
            end
          end
          default: begin
            seq_state <= SEQ_IDLE;
            o_done    <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    delayed_io_seq_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_edge),
      .abort    (i_abort),
      .clear    (clear),
`ifdef DELAYED_IO_REPEAT_EN
      .restart  (boundary),
      .skip     (ch_skip[c]),
`endif
      .en       (i_ch_en[c]),
      .delay    (i_delay[c]),
      .width    (i_width[c]),
      .polarity (i_polarity[c]),
      .pin      (o_io_pins[c]),
      .busy     (o_ch_busy[c]),
      .fin      (ch_fin[c])
    );
  end

endmodule

// File: tb/tb_delayed_io_seq.sv
// Directed self-checking bench for delayed_io_seq (NUM_CH=4, CNT_W=8).
// Samples and drives on the falling edge; the falling edge where i_start rises is cycle 0.
module tb_delayed_io_seq;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         i_start;
  logic                         i_abort;
  logic [NUM_CH-1:0]            i_ch_en;
  logic [NUM_CH-1:0][CNT_W-1:0] i_delay;
  logic [NUM_CH-1:0][CNT_W-1:0] i_width;
  logic [NUM_CH-1:0]            i_polarity;
  logic [NUM_CH-1:0]            o_io_pins;
  logic [NUM_CH-1:0]            o_ch_busy;
  logic                         o_busy;
  logic                         o_done;
`ifdef DELAYED_IO_REPEAT_EN
  logic [CNT_W-1:0]             i_period;
  logic [15:0]                  i_repeat;
  logic                         o_overrun;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  delayed_io_seq #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_ch_en    (i_ch_en),
    .i_delay    (i_delay),
    .i_width    (i_width),
    .i_polarity (i_polarity),
`ifdef DELAYED_IO_REPEAT_EN
    .i_period   (i_period),
    .i_repeat   (i_repeat),
    .o_overrun  (o_overrun),
`endif
    .o_io_pins  (o_io_pins),
    .o_ch_busy  (o_ch_busy),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_ch_en    = '0;
    i_delay    = '0;
    i_width    = '0;
    i_polarity = '1;
`ifdef DELAYED_IO_REPEAT_EN
    i_period   = '0;
    i_repeat   = '0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    i_polarity = 4'b0101;
    tick();
    tick();
    n_total++; if (o_io_pins !== 4'b1010) $display("FAIL reset_pins: got %b expected %b", o_io_pins, 4'b1010); else n_pass++;
    n_total++; if (o_ch_busy !== 4'b0000) $display("FAIL reset_ch_busy: got %b expected 0000", o_ch_busy); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_done); else n_pass++;
    rst_n = 1'b1;
    i_polarity = 4'b1111;
    tick();
    tick();
    n_total++; if (o_io_pins !== 4'b0000) $display("FAIL idle_live_polarity: got %b expected 0000", o_io_pins); else n_pass++;
  endtask

  task automatic test_basic();
    int d[4] = '{0, 3, 10, 1};
    int w[4] = '{2, 1, 5, 0};
    int we;
    logic [3:0] exp_pins;
    logic [3:0] exp_busy;
    for (int c = 0; c < 4; c++) begin
      i_delay[c] = 8'(d[c]);
      i_width[c] = 8'(w[c]);
    end
    i_ch_en    = 4'b1111;
    i_polarity = 4'b1111;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        we = (w[c] == 0) ? 1 : w[c];
        exp_pins[c] = (cyc >= d[c] + 1) && (cyc <= d[c] + we);
        exp_busy[c] = (cyc <= d[c] + we);
      end
      n_total++; if (o_io_pins !== exp_pins) $display("FAIL basic_pins c%0d: got %b expected %b", cyc, o_io_pins, exp_pins); else n_pass++;
      n_total++; if (o_ch_busy !== exp_busy) $display("FAIL basic_ch_busy c%0d: got %b expected %b", cyc, o_ch_busy, exp_busy); else n_pass++;
      n_total++; if (o_done !== (cyc >= 16)) $display("FAIL basic_done c%0d: got %b expected %b", cyc, o_done, cyc >= 16); else n_pass++;
    end
    i_start = 1'b0;
    tick();
    n_total++; if (o_done !== 1'b0) $display("FAIL basic_done_clear: got %b expected 0", o_done); else n_pass++;
    tick();
  endtask

  task automatic test_no_enable();
    i_ch_en = 4'b0000;
    i_start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      n_total++; if (o_done !== 1'b1) $display("FAIL noen_done c%0d: got %b expected 1", cyc, o_done); else n_pass++;
      n_total++; if (o_busy !== 1'b0) $display("FAIL noen_busy c%0d: got %b expected 0", cyc, o_busy); else n_pass++;
    end
    i_start = 1'b0;
    tick();
    n_total++; if (o_done !== 1'b0) $display("FAIL noen_done_c6: got %b expected 0", o_done); else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    i_ch_en    = 4'b0001;
    i_polarity = 4'b1111;
    i_delay[0] = 8'd100;
    i_width[0] = 8'd4;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (cyc <= 50) begin
        n_total++; if (o_io_pins !== 4'b0000 || o_busy !== 1'b1) $display("FAIL abort_pre c%0d: pins %b busy %b expected 0000 1", cyc, o_io_pins, o_busy); else n_pass++;
      end else begin
        n_total++; if (o_io_pins !== 4'b0000 || o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL abort_post c%0d: pins %b busy %b done %b expected 0000 0 0", cyc, o_io_pins, o_busy, o_done); else n_pass++;
      end
      if (cyc == 50) i_abort = 1'b1;
      if (cyc == 51) i_abort = 1'b0;
      if (cyc == 55) i_start = 1'b0;
    end
    i_delay[0] = 8'd2;
    i_width[0] = 8'd1;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      n_total++; if (o_io_pins[0] !== (cyc == 3)) $display("FAIL abort_restart_pin c%0d: got %b expected %b", cyc, o_io_pins[0], cyc == 3); else n_pass++;
      n_total++; if (o_done !== (cyc >= 4)) $display("FAIL abort_restart_done c%0d: got %b expected %b", cyc, o_done, cyc >= 4); else n_pass++;
    end
    i_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_pins;
    i_ch_en    = 4'b0011;
    i_polarity = 4'b1110;
    i_delay[0] = 8'd8;
    i_width[0] = 8'd2;
    i_delay[1] = 8'd0;
    i_width[1] = 8'd3;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      exp_pins = {2'b00, (cyc >= 1 && cyc <= 3), !(cyc >= 9 && cyc <= 10)};
      n_total++; if (o_io_pins !== exp_pins) $display("FAIL b2b_pins c%0d: got %b expected %b", cyc, o_io_pins, exp_pins); else n_pass++;
      n_total++; if (o_done !== (cyc >= 11)) $display("FAIL b2b_done c%0d: got %b expected %b", cyc, o_done, cyc >= 11); else n_pass++;
      if (cyc == 3) i_start = 1'b0;
      if (cyc == 5) begin
        i_start    = 1'b1;
        i_delay[0] = 8'd1;
        i_width[0] = 8'd7;
      end
    end
    i_start = 1'b0;
    tick();
    n_total++; if (o_done !== 1'b0) $display("FAIL b2b_done_clear: got %b expected 0", o_done); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    i_ch_en    = 4'b0001;
    i_polarity = 4'b0000;
    i_delay[0] = 8'd20;
    i_width[0] = 8'd2;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (cyc <= 7) begin
        n_total++; if (o_io_pins !== 4'b1111 || o_busy !== 1'b1) $display("FAIL rstmid_pre c%0d: pins %b busy %b expected 1111 1", cyc, o_io_pins, o_busy); else n_pass++;
      end else begin
        n_total++; if (o_io_pins !== 4'b1111 || o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL rstmid_post c%0d: pins %b busy %b done %b expected 1111 0 0", cyc, o_io_pins, o_busy, o_done); else n_pass++;
      end
      if (cyc == 7) rst_n = 1'b0;
      if (cyc == 9) begin
        rst_n   = 1'b1;
        i_start = 1'b0;
      end
    end
    i_polarity = 4'b1111;
    tick();
  endtask

  task automatic test_max_count();
    i_ch_en    = 4'b0001;
    i_polarity = 4'b1111;
    i_delay[0] = 8'd255;
    i_width[0] = 8'd255;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 513; cyc++) begin
      tick();
      n_total++; if (o_io_pins[0] !== (cyc >= 256 && cyc <= 510)) $display("FAIL max_pin c%0d: got %b expected %b", cyc, o_io_pins[0], cyc >= 256 && cyc <= 510); else n_pass++;
      n_total++; if (o_done !== (cyc >= 511)) $display("FAIL max_done c%0d: got %b expected %b", cyc, o_done, cyc >= 511); else n_pass++;
    end
    i_start = 1'b0;
    tick();
    tick();
  endtask

`ifdef DELAYED_IO_REPEAT_EN
  task automatic test_repeat();
    logic exp_pin;
    i_ch_en    = 4'b0001;
    i_polarity = 4'b1111;
    i_delay[0] = 8'd2;
    i_width[0] = 8'd3;
    i_period   = 8'd10;
    i_repeat   = 16'd2;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      tick();
      exp_pin = (cyc >= 3 && cyc <= 5) || (cyc >= 13 && cyc <= 15) || (cyc >= 23 && cyc <= 25);
      n_total++; if (o_io_pins[0] !== exp_pin) $display("FAIL rep_pin c%0d: got %b expected %b", cyc, o_io_pins[0], exp_pin); else n_pass++;
      n_total++; if (o_done !== (cyc >= 26)) $display("FAIL rep_done c%0d: got %b expected %b", cyc, o_done, cyc >= 26); else n_pass++;
      n_total++; if (o_overrun !== 1'b0) $display("FAIL rep_overrun c%0d: got %b expected 0", cyc, o_overrun); else n_pass++;
    end
    i_start = 1'b0;
    tick();
    tick();
    i_width[0] = 8'd12;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      tick();
      n_total++; if (o_overrun !== (cyc >= 10)) $display("FAIL ovr_flag c%0d: got %b expected %b", cyc, o_overrun, cyc >= 10); else n_pass++;
      n_total++; if (o_done !== (cyc >= 35)) $display("FAIL ovr_done c%0d: got %b expected %b", cyc, o_done, cyc >= 35); else n_pass++;
    end
    i_start = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_no_enable();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_max_count();
`ifdef DELAYED_IO_REPEAT_EN
    test_repeat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/delayed_io_seq.md
DELAYED_IO_SEQ -- requirements
Module: delayed_io_seq

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent delayed output channels (1..32).
REQ-002 Parameter CNT_W, default 32: width of the delay, width and period counters.
REQ-003 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 i_start  input  1  sequence trigger; acts on its rising edge only.
REQ-006 i_abort  input  1  level; cancels any sequence in progress.
REQ-007 i_ch_en  input  NUM_CH  per-channel enable; sampled at the start edge.
REQ-008 i_delay  input  NUM_CH x CNT_W  per-channel delay in cycles from the start edge to assertion.
REQ-009 i_width  input  NUM_CH x CNT_W  per-channel pulse width in cycles.
REQ-010 i_polarity  input  NUM_CH  per-channel active level: 1 = active-high, 0 = active-low.
REQ-011 o_io_pins  output  NUM_CH  registered channel outputs.
REQ-012 o_ch_busy  output  NUM_CH  channel is in DELAY or ACTIVE.
REQ-013 o_busy  output  1  OR of o_ch_busy.
REQ-014 o_done  output  1  sequence complete.

Function
REQ-015 Start-edge detection: a cycle where i_start=1 and the registered previous i_start=0, with the block in IDLE and i_abort=0; this is cycle 0.
REQ-016 At cycle 0, latch i_ch_en, i_delay, i_width and i_polarity per channel; input changes after cycle 0 have no effect until the next sequence.
REQ-017 Channel FSM states and transitions:
  - IDLE -> DELAY at the start edge when the channel is enabled and delay > 0.
  - IDLE -> ACTIVE at the start edge when the channel is enabled and delay = 0.
  - DELAY -> ACTIVE when the delay counter expires.
  - ACTIVE -> DONE when the width counter expires.
  - DONE -> IDLE when the top level returns to IDLE.
REQ-018 Pin timing: o_io_pins[c] is at its active level exactly in cycles D+1 through D+W inclusive, where D is the latched delay and W the latched width.
REQ-019 A width of W=0 is treated as W=1.
REQ-020 A disabled channel stays in IDLE with its pin inactive for the whole sequence.
REQ-021 Inactive pin level equals ~polarity, using the latched polarity during a sequence and the live i_polarity in IDLE.
REQ-022 o_done rises in the first cycle in which every enabled channel is in DONE.
REQ-023 If no channel is enabled at the start edge, o_done rises in cycle 1.
REQ-024 o_done stays high until i_start=0, then all channels return to IDLE on the next cycle.
REQ-025 Start edges arriving while o_busy=1 or o_done=1 are ignored.
REQ-026 Abort: with i_abort=1, every channel returns to IDLE and every pin goes inactive on the next cycle; o_done is not asserted.
REQ-027 Abort wins over a simultaneous start edge.
REQ-028 Counters are unsigned CNT_W-bit down-counters with no wrap: the maximum delay and width, 2^CNT_W-1, are honoured exactly.

Reset
REQ-029 While rst_n=0 at a clock edge, the following are cleared:
  - all channel FSMs to IDLE and all counters to 0;
  - the previous-start register to 0;
  - o_done=0, o_busy=0, o_ch_busy=0.
REQ-030 During and after reset, o_io_pins take the inactive level ~i_polarity.
REQ-031 A reset mid-sequence abandons the sequence with no done pulse.

Configuration
REQ-032 Macro DELAYED_IO_REPEAT_EN adds inputs i_period (CNT_W) and i_repeat (16), both latched at the start edge, and a sticky output o_overrun.
REQ-033 With DELAYED_IO_REPEAT_EN, repeats run as follows:
  - every P=i_period cycles after cycle 0, each enabled channel restarts as at a start edge;
  - this repeats i_repeat additional times;
  - o_done is asserted only after the final repetition completes.
REQ-034 With DELAYED_IO_REPEAT_EN, a channel not yet in DONE at a period boundary continues its current pulse, skips that restart, and sets o_overrun; o_overrun is cleared at the next start edge or by reset.
REQ-035 With DELAYED_IO_REPEAT_EN, P=0 or i_repeat=0 gives single-shot behaviour.
REQ-036 Without DELAYED_IO_REPEAT_EN, the ports in REQ-032 and all repeat logic are absent, and behaviour is single-shot.

Structure
REQ-037 Package delayed_io_pkg shall hold:
  - the channel state enum (IDLE, DELAY, ACTIVE, DONE);
  - the top-level state enum (IDLE, RUN, DONE);
  - the default parameter constants.
REQ-038 Sub-module delayed_io_seq_ch shall implement one channel FSM with its counters and pin register, instantiated NUM_CH times in a generate loop.

Verification
REQ-039 NUM_CH=4, delays {0,3,10,1}, widths {2,1,5,0}, all enabled, polarity 1111 -> ch0 high cycles 1-2, ch1 high cycle 4, ch2 high cycles 11-15, ch3 high cycle 2; o_done rises at cycle 16.
REQ-040 i_ch_en=0000 with a start edge -> o_done=1 at cycle 1 and never o_busy; i_start dropped at cycle 5 -> o_done=0 at cycle 6.
REQ-041 Delay 100, i_abort pulsed at cycle 50 -> pins inactive from cycle 51, o_done never set, and a new start at cycle 60 works normally.
REQ-042 Second start edge at cycle 5 during a busy sequence, plus i_delay changed mid-sequence -> original timing is unchanged.
REQ-043 rst_n=0 at cycle 7 of a delay-20 sequence with polarity 0 -> pin held high, o_busy=0 from cycle 8.
REQ-044 With DELAYED_IO_REPEAT_EN, P=10, i_repeat=2, D=2, W=3 -> pulses at cycles 3-5, 13-15 and 23-25, o_done at cycle 26; with W=12, o_overrun is set at cycle 10.
